decode_buffer: RTL and testbench

Parametrised decode stage with an internal DEPTH-entry instruction queue and a per-register scoreboard, replacing the single-entry decode register and external single-bit reservation. It sits between fetch and register-read/execute: it accepts fetched instructions, decodes them on entry, holds them in order, and issues the head entry only when its source/destination registers are not pending writeback. Branch resolution flushes all queued entries.

---
 rtl/decode_buffer_pkg.sv | 40 ++++
 rtl/decode_buffer_if.sv | 38 +++
 rtl/decode_scoreboard.sv | 46 ++++
 rtl/decode_buffer.sv | 135 +++++++++++++
 tb/tb_decode_buffer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_buffer_pkg.sv
// Shared decode-stage types, field widths and the opcode decoder.
package decode_buffer_pkg;

  localparam int WORD   = 32;
  localparam int ADDR   = 32;
  localparam int W_RD   = 5;
  localparam int W_IMM  = 16;
  localparam int W_OPR  = 32;
  localparam int W_OP   = WORD - (2 * W_RD + W_IMM);
  localparam int D_INFO = 8;

  // Control-word bit positions
  localparam int WRSV   = 0;  // instruction writes its destination register
  localparam int MEM_B  = 1;  // memory access class
  localparam int BR_B   = 2;  // branch class
  localparam int IMM_B  = 3;  // immediate operand form
  localparam int FN_LSB = 4;  // function sub-field, four bits

  typedef struct packed {
    logic [ADDR-1:0]   pc;
    logic [W_RD-1:0]   r0;
    logic [W_RD-1:0]   r1;
    logic [W_IMM-1:0]  imm;
    logic [D_INFO-1:0] d_info;
  } entry_t;

  // Opcodes with the top bit clear write a register; the remaining classes
  // are picked out of the upper opcode bits.
  function automatic logic [D_INFO-1:0] decode_inst(input logic [W_OP-1:0] op);
    logic [D_INFO-1:0] d;
    d                     = {D_INFO{1'b0}};
    d[WRSV]               = ~op[W_OP-1];
    d[MEM_B]              = (op[W_OP-1 -: 2] == 2'b10);
    d[BR_B]               = (op[W_OP-1 -: 3] == 3'b110);
    d[IMM_B]              = op[0];
    d[D_INFO-1:FN_LSB]    = op[4:1];
    return d;
  endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// Fetch, issue and writeback signals of the decode stage.
interface decode_buffer_if;
  import decode_buffer_pkg::*;

  logic              v_i;
  logic [WORD-1:0]   inst_i;
  logic [ADDR-1:0]   pc_i;
  logic              stall_o;
  logic              branch_i;
  logic              stall_i;
  logic              v_o;
  logic [ADDR-1:0]   pc_o;
  logic [W_RD-1:0]   r0_o;
  logic [W_RD-1:0]   r1_o;
  logic [W_OPR-1:0]  r_opr0_i;
  logic [W_OPR-1:0]  r_opr1_i;
  logic [W_OPR-1:0]  opr0_o;
  logic [W_OPR-1:0]  opr1_o;
  logic [W_IMM-1:0]  imm_o;
  logic [D_INFO-1:0] d_info_o;
  logic [W_RD-1:0]   wb_r_o;
  logic              w_reserve_o;
  logic              wb_v_i;
  logic [W_RD-1:0]   wb_r_i;

  modport slave (
    input  v_i, inst_i, pc_i, branch_i, stall_i, r_opr0_i, r_opr1_i, wb_v_i, wb_r_i,
    output stall_o, v_o, pc_o, r0_o, r1_o, opr0_o, opr1_o, imm_o, d_info_o, wb_r_o,
           w_reserve_o
  );

  modport master (
    output v_i, inst_i, pc_i, branch_i, stall_i, r_opr0_i, r_opr1_i, wb_v_i, wb_r_i,
    input  stall_o, v_o, pc_o, r0_o, r1_o, opr0_o, opr1_o, imm_o, d_info_o, wb_r_o,
           w_reserve_o
  );

endinterface

// File: rtl/decode_scoreboard.sv
// Per-register pending-writeback bits; a reservation beats a same-index
// writeback, and register 0 is never marked busy.
module decode_scoreboard
  import decode_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            set_v,
  input  logic [W_RD-1:0] set_r,
  input  logic            clr_v,
  input  logic [W_RD-1:0] clr_r,
  input  logic [W_RD-1:0] rs0,
  input  logic [W_RD-1:0] rs1,
  output logic            hazard
);

  localparam int NREG = 2 ** W_RD;
  localparam logic [NREG-1:0] BIT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;

  // Apply clear first, then set, so a same-cycle reservation wins
  always_comb begin
    set_mask_s = set_v ? (BIT0 << set_r) : {NREG{1'b0}};
    clr_mask_s = clr_v ? (BIT0 << clr_r) : {NREG{1'b0}};
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~BIT0;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Hazard lookup for the two head operands
  always_comb begin
    hazard = busy_r[rs0] | busy_r[rs1];
  end

endmodule

// File: rtl/decode_buffer.sv
// Decode stage: in-order DEPTH-entry queue of decoded instructions whose head
// issues once its registers have no writeback pending.
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  decode_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;

  entry_t        head_s;
  entry_t        new_s;
  logic          full_s;
  logic          enq_s;
  logic          hazard_s;
  logic          v_s;
  logic          issue_s;
  logic          reserve_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [PW:0]   count_nxt_s;

  // Split and decode the incoming fetch word into a queue entry
  always_comb begin
    new_s.pc     = bus.pc_i;
    new_s.r0     = bus.inst_i[2*W_RD+W_IMM-1 -: W_RD];
    new_s.r1     = bus.inst_i[W_RD+W_IMM-1 -: W_RD];
    new_s.imm    = bus.inst_i[W_IMM-1:0];
    new_s.d_info = decode_inst(bus.inst_i[WORD-1 -: W_OP]);
  end

  // Occupancy, accept and issue decisions; a flush blocks both sides
  always_comb begin
    head_s    = mem_r[rd_ptr_r];
    full_s    = (count_r == CNT_FULL);
    enq_s     = bus.v_i & ~full_s & ~bus.branch_i;
    v_s       = (count_r != CNT_ZERO) & ~hazard_s & ~bus.branch_i;
    issue_s   = v_s & ~bus.stall_i;
    reserve_s = issue_s & head_s.d_info[WRSV];
  end

  // Pointer and count update; a flush empties the queue
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    if (bus.branch_i) begin
      rd_ptr_nxt_s = PTR_ZERO;
      wr_ptr_nxt_s = PTR_ZERO;
      count_nxt_s  = CNT_ZERO;
    end else begin
      if (enq_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (issue_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({enq_s, issue_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Queue state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Entry storage, cleared on reset so the head reads zero until first use
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(entry_t){1'b0}};
      end
    end else if (enq_s) begin
      mem_r[wr_ptr_r] <= new_s;
    end
  end

  decode_scoreboard u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_v  (reserve_s),
    .set_r  (head_s.r0),
    .clr_v  (bus.wb_v_i),
    .clr_r  (bus.wb_r_i),
    .rs0    (head_s.r0),
    .rs1    (head_s.r1),
    .hazard (hazard_s)
  );

  // Drive the issue-side outputs from the head entry
  always_comb begin
    bus.stall_o     = full_s;
    bus.v_o         = v_s;
    bus.pc_o        = head_s.pc;
    bus.r0_o        = head_s.r0;
    bus.r1_o        = head_s.r1;
    bus.imm_o       = head_s.imm;
    bus.d_info_o    = head_s.d_info;
    bus.wb_r_o      = head_s.r0;
    bus.w_reserve_o = reserve_s;
    bus.opr0_o      = bus.r_opr0_i;
    bus.opr1_o      = bus.r_opr1_i;
  end

endmodule

// File: tb/tb_decode_buffer.sv
// Randomised and directed bench for decode_buffer with a queue-based model.
module tb_decode_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_buffer_if bus ();

  decode_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [15:0] imm;
    logic [7:0]  di;
    bit          wr;
  } ent_t;

  ent_t exp_q[$];
  bit   m_busy [32];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int r0, input int r1, input int imm);
    return {op[5:0], r0[4:0], r1[4:0], imm[15:0]};
  endfunction

  // Expected entry straight from the instruction-format rules
  function automatic ent_t make_ent(input logic [31:0] inst, input logic [31:0] pc);
    ent_t e;
    int   op;
    op    = int'(inst[31:26]);
    e.pc  = pc;
    e.r0  = inst[25:21];
    e.r1  = inst[20:16];
    e.imm = inst[15:0];
    e.wr  = (op < 32);
    e.di  = 8'(((op / 2) % 16) * 16 + (op % 2) * 8 + int'(op / 8 == 6) * 4
               + int'(op / 16 == 2) * 2 + int'(op < 32));
    return e;
  endfunction

  // Monitor/model: compare at negedge, then advance the model over the next edge
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_v_o", bus.v_o, 0);
        check("rst_stall_o", bus.stall_o, 0);
        check("rst_pc_o", bus.pc_o, 0);
        check("rst_r0_o", bus.r0_o, 0);
        check("rst_r1_o", bus.r1_o, 0);
        check("rst_imm_o", bus.imm_o, 0);
        check("rst_d_info_o", bus.d_info_o, 0);
        check("rst_wb_r_o", bus.wb_r_o, 0);
        check("rst_w_reserve_o", bus.w_reserve_o, 0);
        exp_q.delete();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else begin
        bit   full, haz, ev, iss;
        ent_t h;
        h    = make_ent(32'h0, 32'h0);
        full = (exp_q.size() == DEPTH);
        haz  = 1'b0;
        check("stall_o", bus.stall_o, full);
        if (exp_q.size() != 0) begin
          h   = exp_q[0];
          haz = m_busy[h.r0] | m_busy[h.r1];
          check("pc_o", bus.pc_o, h.pc);
          check("r0_o", bus.r0_o, h.r0);
          check("r1_o", bus.r1_o, h.r1);
          check("imm_o", bus.imm_o, h.imm);
          check("d_info_o", bus.d_info_o, h.di);
          check("wb_r_o", bus.wb_r_o, h.r0);
        end
        ev  = (exp_q.size() != 0) && !haz && !bus.branch_i;
        iss = ev && !bus.stall_i;
        check("v_o", bus.v_o, ev);
        check("w_reserve_o", bus.w_reserve_o, iss && h.wr);
        check("opr0_o", bus.opr0_o, bus.r_opr0_i);
        check("opr1_o", bus.opr1_o, bus.r_opr1_i);
        if (bus.wb_v_i) m_busy[bus.wb_r_i] = 1'b0;
        if (iss && h.wr && h.r0 != 5'd0) m_busy[h.r0] = 1'b1;
        if (bus.branch_i) begin
          exp_q.delete();
        end else begin
          if (iss) void'(exp_q.pop_front());
          if (bus.v_i && !full) exp_q.push_back(make_ent(bus.inst_i, bus.pc_i));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic br, input logic st, input logic wbv, input logic [4:0] wbr);
    bus.v_i      = v;
    bus.inst_i   = inst;
    bus.pc_i     = pc;
    bus.branch_i = br;
    bus.stall_i  = st;
    bus.wb_v_i   = wbv;
    bus.wb_r_i   = wbr;
    bus.r_opr0_i = $urandom();
    bus.r_opr1_i = $urandom();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  // Stimulus
  initial begin
    reset        = 1'b0;
    bus.v_i      = 1'b0;
    bus.inst_i   = 32'h0;
    bus.pc_i     = 32'h0;
    bus.branch_i = 1'b0;
    bus.stall_i  = 1'b0;
    bus.wb_v_i   = 1'b0;
    bus.wb_r_i   = 5'd0;
    bus.r_opr0_i = 32'h0;
    bus.r_opr1_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // three independent back-to-back instructions
    step(1'b1, mk(40, 1, 2, 11), 32'h100, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, mk(40, 3, 4, 12), 32'h104, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, mk(41, 5, 6, 13), 32'h108, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(3);

    // fill to full under downstream stall, fifth held, then drain
    for (int i = 0; i < 5; i++)
      step(1'b1, mk(40, i + 1, i + 2, i), 32'h200 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, mk(40, 5, 6, 4), 32'h210, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, mk(40, 5, 6, 4), 32'h210, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, mk(40, 5, 6, 4), 32'h210, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(6);

    // RAW hazard on r3 released by writeback
    step(1'b1, mk(1, 3, 0, 0), 32'h300, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, mk(40, 1, 3, 0), 32'h304, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(4);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3);
    idle(3);

    // writeback to r3 in the same cycle a new r3 writer issues
    step(1'b1, mk(1, 3, 0, 0), 32'h400, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, mk(40, 3, 3, 0), 32'h404, 1'b0, 1'b0, 1'b1, 5'd3);
    idle(3);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3);
    idle(3);

    // flush with three queued and a new fetch; r5 stays busy across it
    step(1'b1, mk(2, 5, 0, 0), 32'h500, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(2);
    step(1'b1, mk(40, 1, 2, 0), 32'h504, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, mk(40, 1, 2, 0), 32'h508, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, mk(40, 1, 2, 0), 32'h50c, 1'b0, 1'b1, 1'b0, 5'd0);
    step(1'b1, mk(40, 7, 7, 0), 32'h510, 1'b1, 1'b1, 1'b0, 5'd0);
    step(1'b1, mk(40, 5, 1, 0), 32'h514, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(3);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5);
    idle(3);

    // writer to register 0 never creates a hazard
    step(1'b1, mk(3, 0, 0, 0), 32'h600, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, mk(40, 0, 0, 0), 32'h604, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(3);

    // random traffic with one asynchronous reset mid-run
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
      end
      step($urandom_range(3, 0) != 0,
           mk(int'($urandom_range(63, 0)), int'($urandom_range(3, 0)),
              int'($urandom_range(3, 0)), int'($urandom_range(65535, 0))),
           $urandom(), $urandom_range(15, 0) == 0, $urandom_range(3, 0) == 0,
           $urandom_range(2, 0) == 0, 5'($urandom_range(3, 0)));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
